// File: rtl/timer_pkg.sv
// Shared FSM state type and 7-segment glyph table for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } timer_state_e;

  // Active-low segments ordered {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex7seg.sv
// One hex digit to active-low 7-segment decoder.
module hex7seg
  import timer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown timer with pause, clear, optional auto-reload and hex display.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int  CLK_DIV  = 50_000_000,
  parameter int  PERIOD_W = 8,
  localparam int DIGITS   = (PERIOD_W + 3) / 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  reload,
  input  logic [PERIOD_W-1:0]   seconds_period,
  output logic [PERIOD_W-1:0]   seconds_left,
  output logic [7*DIGITS-1:0]   hex_seconds_left,
  output logic                  finished,
  output logic                  expired
);

  localparam int PS_W  = $clog2(CLK_DIV);
  localparam int HEX_W = 4 * DIGITS;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

  timer_state_e          state_q, state_d;
  logic [PERIOD_W-1:0]   seconds_left_q, seconds_left_d;
  logic [PS_W-1:0]       prescaler_q, prescaler_d;
  logic                  expired_q, expired_d;
  logic                  start_q;
  logic                  tick;
  logic                  do_load;

  always_comb begin
    state_d        = state_q;
    seconds_left_d = seconds_left_q;
    prescaler_d    = prescaler_q;
    expired_d      = 1'b0;
    do_load        = 1'b0;
    tick           = (prescaler_q == PS_MAX);

    if (clear) begin
      state_d        = IDLE;
      seconds_left_d = '0;
      prescaler_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) do_load = 1'b1;
        end
        RUN: begin
          // Dropping start wins over a coincident tick.
          if (!start) begin
            state_d = PAUSE;
          end else if (tick) begin
            prescaler_d = '0;
            if (seconds_left_q <= PERIOD_W'(1)) begin
              seconds_left_d = '0;
              state_d        = DONE;
              expired_d      = 1'b1;
            end else begin
              seconds_left_d = seconds_left_q - 1'b1;
            end
          end else begin
            prescaler_d = prescaler_q + 1'b1;
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          if (reload && start) begin
            if (tick) do_load = 1'b1;
            else      prescaler_d = prescaler_q + 1'b1;
          end else if (start && !start_q) begin
            do_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // A zero-length period expires immediately instead of counting.
      if (do_load) begin
        prescaler_d = '0;
        if (seconds_period == '0) begin
          seconds_left_d = '0;
          state_d        = DONE;
          expired_d      = 1'b1;
        end else begin
          seconds_left_d = seconds_period;
          state_d        = RUN;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      seconds_left_q <= '0;
      prescaler_q    <= '0;
      expired_q      <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      seconds_left_q <= seconds_left_d;
      prescaler_q    <= prescaler_d;
      expired_q      <= expired_d;
      start_q        <= start;
    end
  end

  assign seconds_left = seconds_left_q;
  assign finished     = (state_q == DONE);
  assign expired      = expired_q;

  logic [HEX_W-1:0] hex_value;
  assign hex_value = HEX_W'(seconds_left_q);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (hex_value[4*g +: 4]),
      .seg    (hex_seconds_left[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: cycle-accurate reference model plus directed scenarios.
module tb_countdown_timer;

  localparam int CLK_DIV = 4;

  logic        clock = 1'b0;
  logic        reset, start, clear, reload;
  logic [7:0]  period;
  logic [7:0]  dut_left;
  logic [13:0] dut_hex;
  logic        dut_finished, dut_expired;
  logic [11:0] period12;
  logic [11:0] dut12_left;
  logic [20:0] dut12_hex;
  logic        dut12_finished, dut12_expired;

  always #5 clock = ~clock;

  countdown_timer #(.CLK_DIV(CLK_DIV), .PERIOD_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .reload(reload),
    .seconds_period(period), .seconds_left(dut_left), .hex_seconds_left(dut_hex),
    .finished(dut_finished), .expired(dut_expired)
  );

  countdown_timer #(.CLK_DIV(CLK_DIV), .PERIOD_W(12)) dut12 (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .reload(reload),
    .seconds_period(period12), .seconds_left(dut12_left), .hex_seconds_left(dut12_hex),
    .finished(dut12_finished), .expired(dut12_expired)
  );

  int n_compared = 0;
  int n_failed   = 0;
  int cycle      = 0;
  int exp_count  = 0;
  int exp_t_last = 0;
  int exp_t_prev = 0;
  int base;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v & 15)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Reference model: seconds remaining plus how far into the current second we are.
  typedef enum {M_IDLE, M_COUNTING, M_HELD, M_ZERO} mode_t;
  mode_t m_mode;
  int    m_left, m_phase;
  bit    m_expired, m_prev_start;
  bit    model_valid = 1'b0;

  task model_load();
    m_phase = 0;
    m_left  = int'(period);
    if (m_left == 0) begin
      m_mode    = M_ZERO;
      m_expired = 1'b1;
    end else begin
      m_mode = M_COUNTING;
    end
  endtask

  always @(posedge clock) begin
    cycle++;
    if (reset) begin
      m_mode = M_IDLE; m_left = 0; m_phase = 0; m_expired = 1'b0; m_prev_start = 1'b0;
      model_valid = 1'b1;
    end else begin
      m_expired = 1'b0;
      if (clear) begin
        m_mode = M_IDLE; m_left = 0; m_phase = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (start) model_load();
          M_COUNTING: begin
            if (!start) m_mode = M_HELD;
            else begin
              m_phase++;
              if (m_phase == CLK_DIV) begin
                m_phase = 0;
                m_left--;
                if (m_left == 0) begin
                  m_mode    = M_ZERO;
                  m_expired = 1'b1;
                end
              end
            end
          end
          M_HELD: if (start) m_mode = M_COUNTING;
          M_ZERO: begin
            if (reload && start) begin
              m_phase++;
              if (m_phase == CLK_DIV) model_load();
            end else if (start && !m_prev_start) begin
              model_load();
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      m_prev_start = start;
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      checkOutput("cyc_seconds_left", int'(dut_left), m_left);
      checkOutput("cyc_finished", int'(dut_finished), int'(m_mode == M_ZERO));
      checkOutput("cyc_expired", int'(dut_expired), int'(m_expired));
      checkOutput("cyc_hex", int'(dut_hex), int'({seg_of(m_left >> 4), seg_of(m_left)}));
      if (dut_expired) begin
        exp_count++;
        exp_t_prev = exp_t_last;
        exp_t_last = cycle;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic r, input logic [7:0] p);
    start = s; clear = c; reload = r; period = p;
  endtask

  initial begin
    reset = 1'b1; period12 = '0;
    applyStimulus(0, 0, 0, 8'd0);
    cyc(2);
    checkOutput("reset_left", int'(dut_left), 0);
    checkOutput("reset_finished", int'(dut_finished), 0);
    checkOutput("reset_expired", int'(dut_expired), 0);
    checkOutput("reset_hex", int'(dut_hex), 'h2040);

    $display("[TB] one-shot period 3");
    reset = 1'b0;
    applyStimulus(1, 0, 0, 8'd3);
    cyc(1); base = exp_count;
    checkOutput("os_left3", int'(dut_left), 3);
    cyc(4); checkOutput("os_left2", int'(dut_left), 2);
    cyc(4); checkOutput("os_left1", int'(dut_left), 1);
    cyc(4); checkOutput("os_left0", int'(dut_left), 0);
    checkOutput("os_expired", int'(dut_expired), 1);
    checkOutput("os_finished", int'(dut_finished), 1);
    cyc(7);
    checkOutput("os_finished_hold", int'(dut_finished), 1);
    checkOutput("os_pulse_count", exp_count - base, 1);

    $display("[TB] pause and resume");
    applyStimulus(0, 1, 0, 8'd0); cyc(1);
    applyStimulus(1, 0, 0, 8'd5); cyc(1);
    checkOutput("pr_left5", int'(dut_left), 5);
    cyc(6); checkOutput("pr_left4", int'(dut_left), 4);
    applyStimulus(0, 0, 0, 8'd5); cyc(10);
    checkOutput("pr_held", int'(dut_left), 4);
    applyStimulus(1, 0, 0, 8'd5); cyc(2);
    checkOutput("pr_pre_tick", int'(dut_left), 4);
    cyc(1); checkOutput("pr_tick", int'(dut_left), 3);

    $display("[TB] auto reload");
    applyStimulus(0, 1, 0, 8'd0); cyc(1);
    applyStimulus(1, 0, 1, 8'd2); cyc(1);
    checkOutput("rl_left2", int'(dut_left), 2);
    cyc(4); checkOutput("rl_left1", int'(dut_left), 1);
    cyc(4); checkOutput("rl_left0", int'(dut_left), 0);
    checkOutput("rl_expired", int'(dut_expired), 1);
    cyc(4); checkOutput("rl_reload2", int'(dut_left), 2);
    applyStimulus(1, 0, 1, 8'd3);
    cyc(4); checkOutput("rl_left1b", int'(dut_left), 1);
    cyc(4); checkOutput("rl_left0b", int'(dut_left), 0);
    checkOutput("rl_interval", exp_t_last - exp_t_prev, 12);
    cyc(4); checkOutput("rl_reload3", int'(dut_left), 3);

    $display("[TB] zero period");
    applyStimulus(0, 1, 0, 8'd0); cyc(1);
    applyStimulus(1, 0, 0, 8'd0); cyc(1);
    checkOutput("zp_finished", int'(dut_finished), 1);
    checkOutput("zp_expired", int'(dut_expired), 1);
    cyc(1); checkOutput("zp_expired_off", int'(dut_expired), 0);
    applyStimulus(1, 0, 0, 8'd4); cyc(3);
    checkOutput("zp_no_restart", int'(dut_finished), 1);
    applyStimulus(0, 0, 0, 8'd4); cyc(1);
    applyStimulus(1, 0, 0, 8'd4); cyc(1);
    checkOutput("zp_restart_left", int'(dut_left), 4);
    checkOutput("zp_restart_fin", int'(dut_finished), 0);

    $display("[TB] clear during run");
    applyStimulus(0, 1, 0, 8'd0); cyc(1);
    applyStimulus(1, 0, 0, 8'd9); cyc(1);
    cyc(8); checkOutput("cl_left7", int'(dut_left), 7);
    base = exp_count;
    applyStimulus(1, 1, 0, 8'd9); cyc(1);
    checkOutput("cl_left0", int'(dut_left), 0);
    checkOutput("cl_finished", int'(dut_finished), 0);
    applyStimulus(0, 0, 0, 8'd9); cyc(2);
    checkOutput("cl_no_pulse", exp_count - base, 0);

    $display("[TB] reset mid-count");
    applyStimulus(1, 0, 0, 8'd6); cyc(6);
    checkOutput("rs_left5", int'(dut_left), 5);
    reset = 1'b1; cyc(1);
    checkOutput("rs_left0", int'(dut_left), 0);

    $display("[TB] 12-bit hex display");
    period12 = 12'hA3F;
    applyStimulus(1, 0, 0, 8'hA3);
    cyc(1); reset = 1'b0;
    cyc(2);
    checkOutput("hx_left", int'(dut12_left), 'hA3F);
    checkOutput("hx_digit0", int'(dut12_hex[6:0]), int'(7'b0001110));
    checkOutput("hx_digit1", int'(dut12_hex[13:7]), int'(7'b0110000));
    checkOutput("hx_digit2", int'(dut12_hex[20:14]), int'(7'b0001000));
    checkOutput("hx_flags", int'({dut12_finished, dut12_expired}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000, clock cycles per one-second tick (≥2).
REQ-002 SHALL have parameter PERIOD_W, default 8, width of period and seconds count (4..16).
REQ-003 SHALL have derived localparam DIGITS = ceil(PERIOD_W/4), number of hex display digits.
REQ-004 SHALL have port clock  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  level run-enable: 1 = count, 0 = pause.
REQ-007 SHALL have port clear  in  1  synchronous abort to IDLE.
REQ-008 SHALL have port reload  in  1  1 = auto-restart after expiry, 0 = one-shot.
REQ-009 SHALL have port seconds_period  in  PERIOD_W  countdown length in seconds.
REQ-010 SHALL have port seconds_left  out  PERIOD_W  registered remaining seconds.
REQ-011 SHALL have port hex_seconds_left  out  7*DIGITS  active-low 7-seg, hex value of seconds_left, digit 0 in bits [6:0].
REQ-012 SHALL have port finished  out  1  high while in DONE.
REQ-013 SHALL have port expired  out  1  one-cycle pulse on every arrival at zero.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-015 SHALL, in IDLE with start=1, load seconds_left=seconds_period and prescaler=0, and enter RUN; with seconds_period=0, enter DONE and pulse expired instead.
REQ-016 SHALL, in RUN, increment prescaler each cycle; at CLK_DIV-1, wrap to 0 and decrement seconds_left (one tick).
REQ-017 SHALL, on a tick with seconds_left=1, set seconds_left=0, enter DONE, and assert expired in the cycle seconds_left becomes 0.
REQ-018 SHALL, in RUN with start=0, enter PAUSE, holding seconds_left and prescaler unchanged; start=0 beats a coincident tick (no decrement).
REQ-019 SHALL, in PAUSE with start=1, return to RUN, resuming prescaler from its held value.
REQ-020 SHALL, in DONE with reload=1 and start=1, keep running prescaler; next tick reloads seconds_left=seconds_period (re-sampled) and enters RUN (zero displayed exactly one second).
REQ-021 SHALL, in DONE with reload=0 or start=0, hold prescaler; one-shot restart only on rising edge of start (registered start_q), same load as REQ-015.
REQ-022 SHALL sample seconds_period only at load/reload instants; mid-count changes have no effect.
REQ-023 SHALL give clear priority over all events: next cycle IDLE, seconds_left=0, prescaler=0, expired=0.
REQ-024 SHALL size prescaler as $clog2(CLK_DIV) bits; seconds_left never wraps below 0.
REQ-025 SHALL drive hex_seconds_left combinationally from seconds_left (zero latency after register).

Reset
REQ-026 SHALL on reset: state IDLE, seconds_left=0, prescaler=0, start_q=0, finished=0, expired=0; hex digits show "0" (7'b1000000).
REQ-027 SHALL let reset mid-count override every state and input in the same cycle.

Structure
REQ-028 SHALL place FSM state typedef and 7-seg constant table in shared package timer_pkg.
REQ-029 SHALL instantiate sub-module hex7seg (4-bit in, 7-bit active-low out) DIGITS times via generate.

Verification (CLK_DIV=4, PERIOD_W=8)
REQ-030 SHALL check: reset, start=1, period=3, reload=0 -> seconds_left 3,2,1,0 every 4 cycles; expired one pulse; finished stays 1.
REQ-031 SHALL check: period=5, start drops after 6 RUN cycles for 10 cycles -> seconds_left holds 4, prescaler held, resumes with 2 cycles remaining to next tick.
REQ-032 SHALL check: reload=1, period=2 -> sequence 2,1,0,2,1,0; expired pulses every 12 cycles; period changed to 3 mid-count takes effect on next reload only.
REQ-033 SHALL check: period=0, start=1 -> DONE next cycle, expired pulse, finished=1; one-shot restart needs start 0->1.
REQ-034 SHALL check: clear during RUN at seconds_left=7 -> IDLE, seconds_left=0, no expired pulse.
REQ-035 SHALL check: PERIOD_W=12, period=12'hA3F -> hex_seconds_left digits F,3,A (7'b0001110, 7'b0110000, 7'b0001000).
